// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and load data into the decode-stage register file.
// Optional load sub-word extraction/extension is enabled by defining WB_LOAD_EXT_EN.
module wb_stage #(
    parameter int ADDR_LINE = 5,
    parameter int D_SIZE    = 32,
    parameter int LOAD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_reg_wr,
    input  logic                 in_is_load,
    input  logic [ADDR_LINE-1:0] in_dest,
    input  logic [D_SIZE-1:0]    in_alu_data,
    input  logic [D_SIZE-1:0]    mem_read_data,
`ifdef WB_LOAD_EXT_EN
    input  logic [1:0]           in_ld_size,
    input  logic                 in_ld_signed,
`endif
    output logic                 w_f_wb,
    output logic [ADDR_LINE-1:0] addr_in_f_wb,
    output logic [D_SIZE-1:0]    write_data_f_wb,
    output logic                 hazard,
    output logic [31:0]          retire_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             cnt;
    logic [ADDR_LINE-1:0]   pend_dest;
    logic                   pend_wr;
    logic                   accept;
    logic [D_SIZE-1:0]      load_data;

    assign accept = in_valid & in_ready;

`ifdef WB_LOAD_EXT_EN
    logic [1:0] pend_size;
    logic       pend_signed;

    always_comb begin
        load_data = mem_read_data;
        case (pend_size)
            2'd0: load_data = {{(D_SIZE-8){pend_signed & mem_read_data[7]}}, mem_read_data[7:0]};
            2'd1: load_data = {{(D_SIZE-16){pend_signed & mem_read_data[15]}}, mem_read_data[15:0]};
            default: load_data = mem_read_data;
        endcase
    end
`else
    always_comb begin
        load_data = mem_read_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && in_is_load) state_nxt = WAIT;
            WAIT: if (cnt == 3'd1)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        hazard   = (state == WAIT);
    end

    // Suppressed writes (reg_wr=0 or dest 0) still walk through WAIT so load timing is uniform.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_f_wb          <= 1'b0;
            addr_in_f_wb    <= '0;
            write_data_f_wb <= '0;
            retire_count    <= '0;
            cnt             <= '0;
            pend_dest       <= '0;
            pend_wr         <= 1'b0;
`ifdef WB_LOAD_EXT_EN
            pend_size       <= '0;
            pend_signed     <= 1'b0;
`endif
        end else begin
            w_f_wb <= 1'b0;
            if (accept) retire_count <= retire_count + 32'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_is_load) begin
                            cnt       <= 3'(LOAD_LAT);
                            pend_dest <= in_dest;
                            pend_wr   <= in_reg_wr && (in_dest != '0);
`ifdef WB_LOAD_EXT_EN
                            pend_size   <= in_ld_size;
                            pend_signed <= in_ld_signed;
`endif
                        end else if (in_reg_wr && (in_dest != '0)) begin
                            w_f_wb          <= 1'b1;
                            addr_in_f_wb    <= in_dest;
                            write_data_f_wb <= in_alu_data;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1 && pend_wr) begin
                        w_f_wb          <= 1'b1;
                        addr_in_f_wb    <= pend_dest;
                        write_data_f_wb <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage (LOAD_LAT=2); expected writes are queued at drive time
// and popped when w_f_wb pulses. Sub-word load cases run only with WB_LOAD_EXT_EN.
module tb_wb_stage;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_reg_wr, in_is_load;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_data, mem_read_data;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        w_f_wb, hazard;
    logic [4:0]  addr_in_f_wb;
    logic [31:0] write_data_f_wb, retire_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_retire = 0;
    logic [36:0] sb_q[$];
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    wb_stage #(.ADDR_LINE(5), .D_SIZE(32), .LOAD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_wr(in_reg_wr), .in_is_load(in_is_load), .in_dest(in_dest),
        .in_alu_data(in_alu_data), .mem_read_data(mem_read_data),
`ifdef WB_LOAD_EXT_EN
        .in_ld_size(ld_size), .in_ld_signed(ld_signed),
`endif
        .w_f_wb(w_f_wb), .addr_in_f_wb(addr_in_f_wb), .write_data_f_wb(write_data_f_wb),
        .hazard(hazard), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor: pulses must match the queue head, idle cycles must hold the last values.
    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
        end else if (w_f_wb) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_wr", 32'd1, 32'd0);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                check_eq("wr_addr", 32'(addr_in_f_wb), 32'(e[36:32]));
                check_eq("wr_data", write_data_f_wb, e[31:0]);
            end
            last_addr = addr_in_f_wb;
            last_data = write_data_f_wb;
        end else begin
            check_eq("hold_addr", 32'(addr_in_f_wb), 32'(last_addr));
            check_eq("hold_data", write_data_f_wb, last_data);
        end
    end

    task automatic drive_alu(input logic [4:0] dest, input logic [31:0] data, input logic wr);
        in_valid = 1'b1; in_is_load = 1'b0; in_reg_wr = wr;
        in_dest = dest; in_alu_data = data;
        if (wr && dest != 5'd0) sb_q.push_back({dest, data});
        exp_retire++;
        step();
    endtask

    task automatic drive_load(input logic [4:0] dest, input logic [31:0] mem,
                              input logic [31:0] exp_data, input logic wr,
                              input logic [1:0] sz, input logic sg);
        in_valid = 1'b1; in_is_load = 1'b1; in_reg_wr = wr; in_dest = dest;
        in_alu_data = 32'h0BAD_0BAD; ld_size = sz; ld_signed = sg;
        mem_read_data = ~mem;
        if (wr && dest != 5'd0) sb_q.push_back({dest, exp_data});
        exp_retire++;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            mem_read_data = (i == LAT) ? mem : ~mem;
            @(negedge clk);
            check_eq("wait_ready", 32'(in_ready), 32'd0);
            check_eq("wait_hazard", 32'(hazard), 32'd1);
            step();
        end
        mem_read_data = ~mem;
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_reg_wr = 1'b0; in_is_load = 1'b0;
        in_dest = '0; in_alu_data = '0; mem_read_data = '0; ld_size = 2'd2; ld_signed = 1'b0;
        step(); step();
        @(negedge clk);
        check_eq("rst_w", 32'(w_f_wb), 32'd0);
        check_eq("rst_addr", 32'(addr_in_f_wb), 32'd0);
        check_eq("rst_data", write_data_f_wb, 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_hazard", 32'(hazard), 32'd0);
        check_eq("rst_retire", retire_count, 32'd0);
        reset = 1'b0;
        step();

        drive_alu(5'd3, 32'h11, 1'b1);
        drive_alu(5'd4, 32'h22, 1'b1);
        go_idle();
        step(); step();
        check_eq("retire_alu2", retire_count, 32'(exp_retire));

        drive_load(5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0);
        @(negedge clk);
        check_eq("post_ld_ready", 32'(in_ready), 32'd1);
        check_eq("post_ld_hazard", 32'(hazard), 32'd0);
        step(); step();

        drive_alu(5'd0, 32'h99, 1'b1);
        drive_load(5'd7, 32'h0000_1234, 32'h0000_1234, 1'b0, 2'd2, 1'b0);
        go_idle();
        step(); step();
        check_eq("retire_suppr", retire_count, 32'(exp_retire));

        // Accept coincident with the load's write pulse
        drive_load(5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 2'd3, 1'b0);
        drive_alu(5'd10, 32'hA5A5_5A5A, 1'b1);
        drive_alu(5'd31, 32'hFFFF_FFFF, 1'b1);
        go_idle();
        step(); step();
        check_eq("retire_b2b", retire_count, 32'(exp_retire));

`ifdef WB_LOAD_EXT_EN
        drive_load(5'd12, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b1, 2'd0, 1'b1);
        drive_load(5'd13, 32'h1234_F00D, 32'h0000_F00D, 1'b1, 2'd1, 1'b0);
        drive_load(5'd14, 32'h0000_8001, 32'hFFFF_8001, 1'b1, 2'd1, 1'b1);
        drive_alu(5'd15, 32'h0000_00F0, 1'b1);
        go_idle();
        step(); step();
`endif

        // Reset while the load is pending: no write, back to IDLE.
        in_valid = 1'b1; in_is_load = 1'b1; in_reg_wr = 1'b1; in_dest = 5'd6;
        mem_read_data = 32'h7777_7777;
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_retire = 0;
        @(negedge clk);
        check_eq("rstw_ready", 32'(in_ready), 32'd1);
        check_eq("rstw_hazard", 32'(hazard), 32'd0);
        check_eq("rstw_retire", retire_count, 32'd0);
        step(); step(); step();

        // in_valid during reset is neither accepted nor counted.
        reset = 1'b1;
        in_valid = 1'b1; in_is_load = 1'b0; in_reg_wr = 1'b1; in_dest = 5'd8; in_alu_data = 32'h88;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        step(); step();
        check_eq("rstv_retire", retire_count, 32'd0);

        drive_alu(5'd2, 32'h1357_9BDF, 1'b1);
        go_idle();
        step(); step();
        check_eq("retire_final", retire_count, 32'(exp_retire));
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
